bars_timing_sequencer: RTL and testbench

Generates the scanline/pixel strobes and the `video_y` mode word that drive the EBU colour-bar generator.

- Produces `newline`, `newpixel` and `visible_window` so the generator sees exactly 256 equally spaced pixels per visible line.
- Sequences the bar presentation mode frame by frame: quadrant pattern, 100 %, 75 % and reversed bars.
- Sits between the system clock domain and the bar generator, replacing ad-hoc counters in the top level.

---
 rtl/bars_timing_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_bars_timing_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bars_timing_sequencer.sv
// -----------------------------------------------------------------------------
// bars_timing_sequencer
//
// Scanline/pixel timing and presentation-mode sequencer for the EBU colour-bar
// generator. A horizontal/vertical counter pair is decoded into registered
// strobes that give the generator exactly 256 evenly spaced pixels on each of
// 256 visible lines. A frame-rate scheduler steps the bar presentation mode.
//
// Ports:
//   clk            in   system clock (single domain)
//   rst_n          in   asynchronous active-low reset
//   freeze         in   level; holds the frame counter, blocks auto-advance
//   mode_next      in   one-clock request to advance mode at next frame start
//   newline        out  one-clock pulse at the start of every line
//   newpixel       out  one-clock pulse at the end of each active pixel
//   visible_window out  high across the 256-pixel span of visible lines
//   video_y        out  per-line mode word, loaded at line start
//   frame_start    out  one-clock pulse coincident with newline of line 0
//   mode           out  current presentation mode
// -----------------------------------------------------------------------------
module bars_timing_sequencer #(
    parameter int LINE_CLKS          = 3072,
    parameter int ACTIVE_START       = 560,
    parameter int PIXEL_DIV          = 9,
    parameter int LINES_PER_FRAME    = 312,
    parameter int FIRST_VISIBLE_LINE = 23,
    parameter int FRAMES_PER_MODE    = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       freeze,
    input  logic       mode_next,
    output logic       newline,
    output logic       newpixel,
    output logic       visible_window,
    output logic [7:0] video_y,
    output logic       frame_start,
    output logic [1:0] mode
);

    localparam int PW = $clog2(PIXEL_DIV);

    localparam logic [11:0]   H_LAST      = 12'(LINE_CLKS - 1);
    localparam logic [11:0]   H_WIN_FIRST = 12'(ACTIVE_START);
    localparam logic [11:0]   H_WIN_LAST  = 12'(ACTIVE_START + 256 * PIXEL_DIV - 1);
    localparam logic [9:0]    V_LAST      = 10'(LINES_PER_FRAME - 1);
    localparam logic [9:0]    V_FIRST     = 10'(FIRST_VISIBLE_LINE);
    localparam logic [9:0]    V_END       = 10'(FIRST_VISIBLE_LINE + 256);
    localparam logic [PW-1:0] PH_LAST     = PW'(PIXEL_DIV - 1);
    localparam logic [7:0]    FCNT_LAST   = 8'(FRAMES_PER_MODE - 1);

    // Elaboration-time parameter legality.
    if (ACTIVE_START + 256 * PIXEL_DIV > LINE_CLKS) begin : g_bad_hwin
        $error("active span does not fit in LINE_CLKS");
    end
    if (FIRST_VISIBLE_LINE + 256 > LINES_PER_FRAME) begin : g_bad_vwin
        $error("visible lines do not fit in LINES_PER_FRAME");
    end
    if (PIXEL_DIV < 2) begin : g_bad_div
        $error("PIXEL_DIV must be at least 2");
    end
    if (LINE_CLKS > 4096 || LINES_PER_FRAME > 1024) begin : g_bad_cnt
        $error("counter widths too small for LINE_CLKS/LINES_PER_FRAME");
    end
    if (FRAMES_PER_MODE < 1 || FRAMES_PER_MODE > 255) begin : g_bad_fpm
        $error("FRAMES_PER_MODE must be in 1..255");
    end

    logic [11:0]   hcnt_q, hcnt_d;
    logic [9:0]    vcnt_q, vcnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          pending_q, pending_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    video_y_q, video_y_d;
    logic          newline_q, newline_d;
    logic          newpixel_q, newpixel_d;
    logic          window_q, window_d;
    logic          frame_start_q, frame_start_d;

    logic       line_start;
    logic       frame_bound;
    logic       vis_line;
    logic       in_win;
    logic [7:0] v_idx;

    // Counters. The pixel phase realigns to zero on the first active clock of
    // every line, so no divide/modulo of hcnt is needed.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        hcnt_d  = (hcnt_q == H_LAST) ? 12'd0 : hcnt_q + 12'd1;
        vcnt_d  = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        if (hcnt_d == H_WIN_FIRST || phase_q == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Mode scheduler. Auto-advance and a pending request on the same boundary
    // share one increment. A request on the boundary clock itself is kept for
    // the following boundary.
    always_comb begin
        line_start  = (hcnt_q == 12'd0);
        frame_bound = line_start && (vcnt_q == 10'd0);
        fcnt_d      = fcnt_q;
        mode_d      = mode_q;
        pending_d   = pending_q | mode_next;
        if (frame_bound) begin
            pending_d = mode_next;
            if (pending_q || (fcnt_q == FCNT_LAST && !freeze)) begin
                mode_d = mode_q + 2'd1;
                fcnt_d = 8'd0;
            end else if (!freeze) begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // Output decode from the current counter state; registered below.
    always_comb begin
        vis_line      = (vcnt_q >= V_FIRST) && (vcnt_q < V_END);
        v_idx         = 8'(vcnt_q - V_FIRST);
        in_win        = vis_line && (hcnt_q >= H_WIN_FIRST) && (hcnt_q <= H_WIN_LAST);
        newline_d     = line_start;
        frame_start_d = frame_bound;
        window_d      = in_win;
        newpixel_d    = in_win && (phase_q == PH_LAST);
        video_y_d     = video_y_q;
        if (line_start) begin
            if (!vis_line) begin
                video_y_d = 8'd0;
            end else begin
                // mode_d so that line 0 already carries the new frame's mode.
                unique case (mode_d)
                    2'd0:    video_y_d = v_idx;
                    2'd1:    video_y_d = {2'b01, v_idx[5:0]};
                    2'd2:    video_y_d = {2'b00, v_idx[5:0]};
                    default: video_y_d = {2'b11, v_idx[5:0]};
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            phase_q       <= '0;
            fcnt_q        <= '0;
            pending_q     <= 1'b0;
            mode_q        <= '0;
            video_y_q     <= '0;
            newline_q     <= 1'b0;
            newpixel_q    <= 1'b0;
            window_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            phase_q       <= phase_d;
            fcnt_q        <= fcnt_d;
            pending_q     <= pending_d;
            mode_q        <= mode_d;
            video_y_q     <= video_y_d;
            newline_q     <= newline_d;
            newpixel_q    <= newpixel_d;
            window_q      <= window_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign newline        = newline_q;
    assign newpixel       = newpixel_q;
    assign visible_window = window_q;
    assign video_y        = video_y_q;
    assign frame_start    = frame_start_q;
    assign mode           = mode_q;

endmodule

// File: tb/tb_bars_timing_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bars_timing_sequencer
//
// Directed bench for bars_timing_sequencer with default line timing and
// FRAMES_PER_MODE=2. Long stretches of a frame are skipped by loading the
// counters one clock before the line or frame of interest.
// -----------------------------------------------------------------------------
module tb_bars_timing_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       freeze = 1'b0;
    logic       mode_next = 1'b0;
    logic       newline;
    logic       newpixel;
    logic       visible_window;
    logic [7:0] video_y;
    logic       frame_start;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] jump_h;
    logic [9:0]  jump_v;

    bars_timing_sequencer #(
        .FRAMES_PER_MODE(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .freeze        (freeze),
        .mode_next     (mode_next),
        .newline       (newline),
        .newpixel      (newpixel),
        .visible_window(visible_window),
        .video_y       (video_y),
        .frame_start   (frame_start),
        .mode          (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Load the counters so the next edge decodes (h, v); returns after that
    // edge, i.e. with the counters holding the following position.
    task automatic jump_to(input logic [11:0] h, input logic [9:0] v);
        @(negedge clk);
        jump_h = h;
        jump_v = v;
        force dut.hcnt_q = jump_h;
        force dut.vcnt_q = jump_v;
        #1;
        release dut.hcnt_q;
        release dut.vcnt_q;
        @(negedge clk);
    endtask

    // Run up to a frame boundary, optionally with mode_next on the boundary
    // clock, and check the resulting mode.
    task automatic frame_boundary(input string tag, input logic nxt, input logic [1:0] exp_mode);
        jump_to(12'd3071, 10'd311);
        mode_next = nxt;
        @(negedge clk);
        mode_next = 1'b0;
        check({tag, "_frame_start"}, frame_start, 1);
        check({tag, "_mode"}, mode, exp_mode);
    endtask

    // Observe one full line starting with counters at hcnt=0.
    task automatic scan_line(output int n_pix, output int first_pix, output int last_pix,
                             output int n_win, output int first_win, output int n_nl);
        n_pix = 0; first_pix = -1; last_pix = -1;
        n_win = 0; first_win = -1; n_nl = 0;
        for (int i = 0; i < 3072; i++) begin
            @(negedge clk);
            if (newline) n_nl++;
            if (newpixel) begin
                n_pix++;
                if (first_pix < 0) first_pix = i;
                last_pix = i;
            end
            if (visible_window) begin
                n_win++;
                if (first_win < 0) first_win = i;
            end
        end
    endtask

    task automatic pulse_mode_next();
        @(negedge clk);
        mode_next = 1'b1;
        @(negedge clk);
        mode_next = 1'b0;
    endtask

    // video_y for v=200 in modes 0..3
    logic [7:0] vy_tab [4] = '{8'hC8, 8'h48, 8'h08, 8'hC8};
    // Mode after boundaries 2..8 with freeze low
    logic [1:0] step_tab [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    initial begin
        int n, n_pix, first_pix, last_pix, n_win, first_win, n_nl;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_newline", newline, 0);
        check("rst_newpixel", newpixel, 0);
        check("rst_window", visible_window, 0);
        check("rst_video_y", video_y, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_mode", mode, 0);

        // First edge after release: line 0 of frame (boundary 1)
        rst_n = 1'b1;
        @(negedge clk);
        check("first_newline", newline, 1);
        check("first_frame_start", frame_start, 1);
        check("first_mode", mode, 0);
        check("line0_video_y", video_y, 0);

        // newline period
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!newline && n < 4000);
        check("newline_period", n, 3072);
        check("line1_frame_start", frame_start, 0);

        // Lines 22 and 23
        jump_to(12'd3071, 10'd21);
        scan_line(n_pix, first_pix, last_pix, n_win, first_win, n_nl);
        check("line22_pixels", n_pix, 0);
        check("line22_window", n_win, 0);
        check("line22_newline", n_nl, 1);
        scan_line(n_pix, first_pix, last_pix, n_win, first_win, n_nl);
        check("line23_pixels", n_pix, 256);
        check("line23_first_pix", first_pix, 568);
        check("line23_last_pix", last_pix, 2863);
        check("line23_win_width", n_win, 2304);
        check("line23_win_rise", first_win, 560);
        check("line23_last_pix_in_win", last_pix, first_win + n_win - 1);

        // Line 279: first line after the visible block
        jump_to(12'd3071, 10'd278);
        scan_line(n_pix, first_pix, last_pix, n_win, first_win, n_nl);
        check("line279_pixels", n_pix, 0);
        check("line279_window", n_win, 0);

        // Line 223 (v=200) in mode 0
        jump_to(12'd3071, 10'd222);
        @(negedge clk);
        check("line223_newline", newline, 1);
        check("m0_video_y", video_y, 8'hC8);

        // Auto stepping every 2 frames, video_y for each mode
        for (int b = 0; b < 7; b++) begin
            frame_boundary($sformatf("auto_b%0d", b + 2), 1'b0, step_tab[b]);
            jump_to(12'd3071, 10'd222);
            @(negedge clk);
            check($sformatf("auto_b%0d_video_y", b + 2), video_y, vy_tab[step_tab[b]]);
        end

        // Freeze holds the mode
        freeze = 1'b1;
        frame_boundary("frz_b9", 1'b0, 2'd0);
        frame_boundary("frz_b10", 1'b0, 2'd0);
        frame_boundary("frz_b11", 1'b0, 2'd0);

        // mode_next mid-frame under freeze: one increment at next boundary
        pulse_mode_next();
        repeat (5) @(negedge clk);
        check("req_midframe_mode", mode, 0);
        frame_boundary("req_b12", 1'b0, 2'd1);
        frame_boundary("req_b13", 1'b0, 2'd1);

        // Request coinciding with auto-advance: single increment
        freeze = 1'b0;
        frame_boundary("coin_b14", 1'b0, 2'd1);
        pulse_mode_next();
        frame_boundary("coin_b15", 1'b0, 2'd2);
        frame_boundary("coin_b16", 1'b0, 2'd2);
        // Request on the boundary clock: auto step now, request next boundary
        frame_boundary("edge_b17", 1'b1, 2'd3);
        frame_boundary("edge_b18", 1'b0, 2'd0);
        frame_boundary("edge_b19", 1'b0, 2'd0);
        frame_boundary("edge_b20", 1'b0, 2'd1);

        // Reset at hcnt=1000 of line 100 (v=77) with a request pending
        jump_to(12'd3071, 10'd99);
        repeat (500) @(negedge clk);
        mode_next = 1'b1;
        @(negedge clk);
        mode_next = 1'b0;
        repeat (499) @(negedge clk);
        check("pre_rst_window", visible_window, 1);
        check("pre_rst_video_y", video_y, 8'h4D);
        check("pre_rst_mode", mode, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_window", visible_window, 0);
        check("arst_video_y", video_y, 0);
        check("arst_mode", mode, 0);
        check("arst_newline", newline, 0);
        check("arst_newpixel", newpixel, 0);
        check("arst_frame_start", frame_start, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_newline", newline, 1);
        check("rel_frame_start", frame_start, 1);
        check("rel_mode", mode, 0);
        check("rel_video_y", video_y, 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (newpixel || visible_window) n++;
        end
        check("rel_no_pixels", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
